// File: rtl/m2_pkg.sv
// m2 block scheduler shared definitions
// states, planes, plane geometry and address constants
package m2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_FS,
        ST_PRE_CT,
        ST_MEGA_A,
        ST_MEGA_B,
        ST_POST_CS,
        ST_POST_WS,
        ST_DONE
    } m2_state_e;

    typedef enum logic [1:0] {
        PL_Y,
        PL_U,
        PL_V
    } m2_plane_e;

    localparam logic [17:0] FETCH_BASE = 18'd76800;

    localparam logic [17:0] FS_OFF_Y = 18'd0;
    localparam logic [17:0] FS_OFF_U = 18'd76800;
    localparam logic [17:0] FS_OFF_V = 18'd115200;

    localparam logic [17:0] WS_OFF_Y = 18'd0;
    localparam logic [17:0] WS_OFF_U = 18'd38400;
    localparam logic [17:0] WS_OFF_V = 18'd57600;

    localparam logic [8:0] FS_STRIDE_Y  = 9'd320;
    localparam logic [8:0] FS_STRIDE_UV = 9'd160;
    localparam logic [8:0] WS_STRIDE_Y  = 9'd160;
    localparam logic [8:0] WS_STRIDE_UV = 9'd80;

    localparam logic [5:0]  Y_COLS   = 6'd40;
    localparam logic [5:0]  UV_COLS  = 6'd20;
    localparam logic [4:0]  ROWS     = 5'd30;
    localparam logic [11:0] N_BLOCKS = 12'd2400;

endpackage

// File: rtl/m2_block_cursor.sv
// m2 block cursor: col/row/plane walk over the frame
// plus shift/add base address and stride for fetch or write side
module m2_block_cursor
    import m2_pkg::*;
#(
    parameter bit FETCH = 1'b1
)
(
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        clear,
    input  logic        advance,
    output logic [17:0] base_addr,
    output logic [8:0]  stride
);

    logic [5:0]  col;
    logic [4:0]  row;
    m2_plane_e   plane;
    logic [5:0]  last_col;
    logic [17:0] row_w;
    logic [17:0] col_w;
    logic [17:0] off;
    logic [17:0] row_term;
    logic [17:0] col_term;

    assign last_col = (plane == PL_Y) ? Y_COLS - 6'd1 : UV_COLS - 6'd1;

    // raster walk: col wraps into row, row wraps into next plane
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            col   <= '0;
            row   <= '0;
            plane <= PL_Y;
        end else if (clear) begin
            col   <= '0;
            row   <= '0;
            plane <= PL_Y;
        end else if (advance) begin
            if (col == last_col) begin
                col <= '0;
                if (row == ROWS - 5'd1) begin
                    row <= '0;
                    unique case (plane)
                        PL_Y:    plane <= PL_U;
                        PL_U:    plane <= PL_V;
                        default: plane <= PL_Y;
                    endcase
                end else begin
                    row <= row + 5'd1;
                end
            end else begin
                col <= col + 6'd1;
            end
        end
    end

    // base = offset + row*8*stride + col*step, built from shifts only
    always_comb begin
        row_w    = {13'd0, row};
        col_w    = {12'd0, col};
        off      = '0;
        row_term = '0;
        col_term = '0;
        stride   = '0;
        if (FETCH) begin
            col_term = col_w << 3;
            unique case (plane)
                PL_Y: begin
                    off      = FETCH_BASE + FS_OFF_Y;
                    row_term = (row_w << 11) + (row_w << 9);
                    stride   = FS_STRIDE_Y;
                end
                PL_U: begin
                    off      = FETCH_BASE + FS_OFF_U;
                    row_term = (row_w << 10) + (row_w << 8);
                    stride   = FS_STRIDE_UV;
                end
                default: begin
                    off      = FETCH_BASE + FS_OFF_V;
                    row_term = (row_w << 10) + (row_w << 8);
                    stride   = FS_STRIDE_UV;
                end
            endcase
        end else begin
            col_term = col_w << 2;
            unique case (plane)
                PL_Y: begin
                    off      = WS_OFF_Y;
                    row_term = (row_w << 10) + (row_w << 8);
                    stride   = WS_STRIDE_Y;
                end
                PL_U: begin
                    off      = WS_OFF_U;
                    row_term = (row_w << 9) + (row_w << 7);
                    stride   = WS_STRIDE_UV;
                end
                default: begin
                    off      = WS_OFF_V;
                    row_term = (row_w << 9) + (row_w << 7);
                    stride   = WS_STRIDE_UV;
                end
            endcase
        end
        base_addr = off + row_term + col_term;
    end

endmodule

// File: rtl/m2_block_scheduler.sv
// m2 block scheduler: pipelines fetch/CT/CS/write engines
// over every 8x8 block of a Y/U/V frame
module m2_block_scheduler
    import m2_pkg::*;
(
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        start,
    input  logic        fs_done,
    input  logic        ct_done,
    input  logic        cs_done,
    input  logic        ws_done,
    output logic        fs_start,
    output logic        ct_start,
    output logic        cs_start,
    output logic        ws_start,
    output logic [17:0] fs_base_addr,
    output logic [17:0] ws_base_addr,
    output logic [8:0]  fs_stride,
    output logic [8:0]  ws_stride,
    output logic        busy,
    output logic        done
);

    m2_state_e   state;
    m2_state_e   state_n;
    logic        flag_0;
    logic        flag_1;
    logic [11:0] blk_cnt;
    logic        in_a;
    logic        in_b;
    logic        got_0;
    logic        got_1;
    logic        both;
    logic        enter;
    logic        frame_clr;
    logic        fs_adv;
    logic        ws_adv;

    // MEGA_A waits on cs+fs, MEGA_B on ct+ws; flag_0/1 hold early dones
    always_comb begin
        in_a  = (state == ST_MEGA_A);
        in_b  = (state == ST_MEGA_B);
        got_0 = flag_0 | (in_a ? cs_done : ct_done);
        got_1 = flag_1 | (in_a ? fs_done : ws_done);
        both  = got_0 & got_1;
        state_n = state;
        unique case (state)
            ST_IDLE:    if (start)   state_n = ST_PRE_FS;
            ST_PRE_FS:  if (fs_done) state_n = ST_PRE_CT;
            ST_PRE_CT:  if (ct_done) state_n = ST_MEGA_A;
            ST_MEGA_A:  if (both)    state_n = ST_MEGA_B;
            ST_MEGA_B: begin
                if (both) begin
                    if (blk_cnt == N_BLOCKS - 12'd2)
                        state_n = ST_POST_CS;
                    else
                        state_n = ST_MEGA_A;
                end
            end
            ST_POST_CS: if (cs_done) state_n = ST_POST_WS;
            ST_POST_WS: if (ws_done) state_n = ST_DONE;
            default:    state_n = ST_IDLE;
        endcase
        enter     = (state_n != state);
        frame_clr = (state == ST_IDLE) & start;
        fs_adv    = fs_done & ((state == ST_PRE_FS) | (in_a & ~flag_1));
        ws_adv    = ws_done & ((state == ST_POST_WS) | (in_b & ~flag_1));
    end

    // state, sticky done flags, block index and registered pulses
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            flag_0   <= 1'b0;
            flag_1   <= 1'b0;
            blk_cnt  <= '0;
            fs_start <= 1'b0;
            ct_start <= 1'b0;
            cs_start <= 1'b0;
            ws_start <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_n;
            if (enter || !(in_a || in_b)) begin
                flag_0 <= 1'b0;
                flag_1 <= 1'b0;
            end else begin
                flag_0 <= got_0;
                flag_1 <= got_1;
            end
            if (frame_clr)
                blk_cnt <= '0;
            else if (in_b && both)
                blk_cnt <= blk_cnt + 12'd1;
            fs_start <= enter & ((state_n == ST_PRE_FS) |
                                 (state_n == ST_MEGA_A));
            ct_start <= enter & ((state_n == ST_PRE_CT) |
                                 (state_n == ST_MEGA_B));
            cs_start <= enter & ((state_n == ST_MEGA_A) |
                                 (state_n == ST_POST_CS));
            ws_start <= enter & ((state_n == ST_MEGA_B) |
                                 (state_n == ST_POST_WS));
            busy     <= (state_n != ST_IDLE);
            done     <= enter & (state_n == ST_DONE);
        end
    end

    m2_block_cursor #(
        .FETCH (1'b1)
    ) u_fs_cursor (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .clear      (frame_clr),
        .advance    (fs_adv),
        .base_addr  (fs_base_addr),
        .stride     (fs_stride)
    );

    m2_block_cursor #(
        .FETCH (1'b0)
    ) u_ws_cursor (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .clear      (frame_clr),
        .advance    (ws_adv),
        .base_addr  (ws_base_addr),
        .stride     (ws_stride)
    );

endmodule

// File: tb/tb_m2_block_scheduler.sv
// m2 block scheduler bench
// engine models answer starts; scoreboard holds expected addresses
module tb_m2_block_scheduler;

    typedef struct {
        int addr;
        int stride;
    } exp_t;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn;
    logic        start;
    logic        fs_done, ct_done, cs_done, ws_done;
    logic        fs_mdl = 1'b0, ct_mdl = 1'b0;
    logic        cs_mdl = 1'b0, ws_mdl = 1'b0;
    logic        ws_inj;
    logic        fs_start, ct_start, cs_start, ws_start;
    logic [17:0] fs_base_addr, ws_base_addr;
    logic [8:0]  fs_stride, ws_stride;
    logic        busy, done;

    logic s_fs = 1'b0, s_ct = 1'b0, s_cs = 1'b0, s_ws = 1'b0;

    exp_t fq[$];
    exp_t wq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_fs, n_ct, n_cs, n_ws, n_done;
    int last_fs = -1, last_ct = -1, last_cs = -1, last_ws = -1;
    int lat_fs = 3, lat_ct = 6, lat_cs = 3, lat_ws = 3;
    int cnt_fs = 0, cnt_ct = 0, cnt_cs = 0, cnt_ws = 0;
    int last_fs_addr, last_ws_addr;
    int a_fs0, a_fs40, a_fs1200, a_ws1200, s_ws1200;

    assign fs_done = fs_mdl;
    assign ct_done = ct_mdl;
    assign cs_done = cs_mdl;
    assign ws_done = ws_mdl | ws_inj;

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    m2_block_scheduler dut (
        .CLOCK_50_I   (CLOCK_50_I),
        .resetn       (resetn),
        .start        (start),
        .fs_done      (fs_done),
        .ct_done      (ct_done),
        .cs_done      (cs_done),
        .ws_done      (ws_done),
        .fs_start     (fs_start),
        .ct_start     (ct_start),
        .cs_start     (cs_start),
        .ws_start     (ws_start),
        .fs_base_addr (fs_base_addr),
        .ws_base_addr (ws_base_addr),
        .fs_stride    (fs_stride),
        .ws_stride    (ws_stride),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic exp_t model_addr(input bit fetch, input int k);
        exp_t r;
        int p, idx, cols, brow, bcol, s, off;
        if (k < 1200) begin
            p = 0; idx = k;
        end else if (k < 1800) begin
            p = 1; idx = k - 1200;
        end else begin
            p = 2; idx = k - 1800;
        end
        cols = (p == 0) ? 40 : 20;
        brow = idx / cols;
        bcol = idx % cols;
        if (fetch) begin
            s   = (p == 0) ? 320 : 160;
            off = 76800 + ((p == 0) ? 0 : (p == 1) ? 76800 : 115200);
            r.addr = off + brow * 8 * s + bcol * 8;
        end else begin
            s   = (p == 0) ? 160 : 80;
            off = (p == 0) ? 0 : (p == 1) ? 38400 : 57600;
            r.addr = off + brow * 8 * s + bcol * 4;
        end
        r.stride = s;
        return r;
    endfunction

    task automatic new_frame();
        fq.delete();
        wq.delete();
        for (int k = 0; k < 2400; k++) begin
            fq.push_back(model_addr(1'b1, k));
            wq.push_back(model_addr(1'b0, k));
        end
        n_fs = 0; n_ct = 0; n_cs = 0; n_ws = 0; n_done = 0;
    endtask

    // dones as sampled by the DUT
    always @(posedge CLOCK_50_I) begin
        s_fs <= fs_done;
        s_ct <= ct_done;
        s_cs <= cs_done;
        s_ws <= ws_done;
    end

    // monitor + scoreboard + engine models
    always @(negedge CLOCK_50_I) begin
        exp_t e;
        cyc++;
        if (s_fs) last_fs = cyc;
        if (s_ct) last_ct = cyc;
        if (s_cs) last_cs = cyc;
        if (s_ws) last_ws = cyc;
        if (resetn) begin
            if (fs_start) begin
                if (n_fs > 0)
                    check("fs_start_time", cyc, max2(last_ct, last_ws));
                check("fs_q_avail", fq.size() > 0, 1);
                if (fq.size() > 0) begin
                    e = fq.pop_front();
                    check("fs_addr", fs_base_addr, e.addr);
                    check("fs_stride", fs_stride, e.stride);
                end
                if (n_fs == 0)    a_fs0    = fs_base_addr;
                if (n_fs == 40)   a_fs40   = fs_base_addr;
                if (n_fs == 1200) a_fs1200 = fs_base_addr;
                last_fs_addr = fs_base_addr;
                n_fs++;
            end
            if (ct_start) begin
                check("ct_start_time", cyc, max2(last_fs, last_cs));
                n_ct++;
            end
            if (cs_start) begin
                check("cs_start_time", cyc, max2(last_ct, last_ws));
                n_cs++;
            end
            if (ws_start) begin
                check("ws_start_time", cyc, max2(last_fs, last_cs));
                check("ws_q_avail", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    e = wq.pop_front();
                    check("ws_addr", ws_base_addr, e.addr);
                    check("ws_stride", ws_stride, e.stride);
                end
                if (n_ws == 1200) begin
                    a_ws1200 = ws_base_addr;
                    s_ws1200 = ws_stride;
                end
                last_ws_addr = ws_base_addr;
                n_ws++;
            end
            if (done) begin
                check("done_time", cyc, last_ws);
                n_done++;
            end
        end
        fs_mdl = (cnt_fs == 1);
        ct_mdl = (cnt_ct == 1);
        cs_mdl = (cnt_cs == 1);
        ws_mdl = (cnt_ws == 1);
        if (cnt_fs > 0) cnt_fs--;
        if (cnt_ct > 0) cnt_ct--;
        if (cnt_cs > 0) cnt_cs--;
        if (cnt_ws > 0) cnt_ws--;
        if (resetn && fs_start) cnt_fs = lat_fs;
        if (resetn && ct_start) cnt_ct = lat_ct;
        if (resetn && cs_start) cnt_cs = lat_cs;
        if (resetn && ws_start) cnt_ws = lat_ws;
        if (!resetn) begin
            cnt_fs = 0; cnt_ct = 0; cnt_cs = 0; cnt_ws = 0;
            fs_mdl = 1'b0; ct_mdl = 1'b0;
            cs_mdl = 1'b0; ws_mdl = 1'b0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_fs_start"}, fs_start, 0);
        check({tag, "_ct_start"}, ct_start, 0);
        check({tag, "_cs_start"}, cs_start, 0);
        check({tag, "_ws_start"}, ws_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fs_addr"}, fs_base_addr, 76800);
        check({tag, "_ws_addr"}, ws_base_addr, 0);
        check({tag, "_fs_stride"}, fs_stride, 320);
        check({tag, "_ws_stride"}, ws_stride, 160);
    endtask

    task automatic pulse_start();
        @(posedge CLOCK_50_I);
        #1 start = 1'b1;
        @(posedge CLOCK_50_I);
        #1 start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        int g;
        g = 0;
        while (n_done < 1 && g < 40000) begin
            @(posedge CLOCK_50_I);
            g++;
        end
        check({tag, "_done_seen"}, n_done >= 1, 1);
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        check({tag, "_n_fs"}, n_fs, 2400);
        check({tag, "_n_ct"}, n_ct, 2400);
        check({tag, "_n_cs"}, n_cs, 2400);
        check({tag, "_n_ws"}, n_ws, 2400);
        check({tag, "_n_done"}, n_done, 1);
        check({tag, "_fq_left"}, fq.size(), 0);
        check({tag, "_wq_left"}, wq.size(), 0);
        check({tag, "_last_fs"}, last_fs_addr, 229272);
        check({tag, "_last_ws"}, last_ws_addr, 76236);
        check({tag, "_fs40"}, a_fs40, 79360);
        check({tag, "_fs1200"}, a_fs1200, 153600);
        check({tag, "_ws1200"}, a_ws1200, 38400);
        check({tag, "_ws_stride_u"}, s_ws1200, 80);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_after"}, done, 0);
    endtask

    initial begin
        int g;
        resetn = 1'b0;
        start  = 1'b0;
        ws_inj = 1'b0;
        #5;
        check_idle_outputs("reset");
        repeat (3) @(posedge CLOCK_50_I);
        #1 resetn = 1'b1;

        // frame A: ct slower than ws, stray ws_done and busy start
        new_frame();
        pulse_start();
        #1;
        check("a_first_fs_start", fs_start, 1);
        check("a_first_fs_addr", fs_base_addr, 76800);
        check("a_first_busy", busy, 1);
        g = 0;
        while (n_ct < 1 && g < 100) begin
            @(posedge CLOCK_50_I);
            g++;
        end
        check("a_pre_ct_seen", n_ct, 1);
        #1;
        ws_inj = 1'b1;
        start  = 1'b1;
        @(posedge CLOCK_50_I);
        #1;
        ws_inj = 1'b0;
        start  = 1'b0;
        check("a_busy_hold", busy, 1);
        run_to_done("a");

        // frame B: reset in MEGA_B of block 500, then restart
        lat_ct = 3;
        new_frame();
        pulse_start();
        g = 0;
        while (n_ws < 501 && g < 20000) begin
            @(posedge CLOCK_50_I);
            g++;
        end
        check("b_ws500_seen", n_ws, 501);
        #1 resetn = 1'b0;
        #1;
        check_idle_outputs("midreset");
        repeat (3) @(posedge CLOCK_50_I);
        #1 resetn = 1'b1;
        new_frame();
        pulse_start();
        g = 0;
        while (n_fs < 3 && g < 200) begin
            @(posedge CLOCK_50_I);
            g++;
        end
        check("b_restart_fs", n_fs >= 3, 1);
        check("b_restart_fs0", a_fs0, 76800);
        check("b_restart_busy", busy, 1);
        resetn = 1'b0;
        repeat (2) @(posedge CLOCK_50_I);
        #1 resetn = 1'b1;

        // frame C: cs_done 5 cycles ahead of fs_done
        lat_fs = 8;
        lat_cs = 3;
        new_frame();
        pulse_start();
        run_to_done("c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
